// File: rtl/pll_freq_monitor_if.sv
// pll_freq_monitor_if
//   Groups the reference input and the status outputs of the PLL frequency monitor.
//   The master modport is the monitor itself. It receives ref_toggle and drives the status outputs.
//   The slave modport is the consumer. It drives ref_toggle and reads the status outputs.
//
//   ref_toggle  reference toggle from the crystal domain (asynchronous to clkin)
//   locked      frequency-in-range indication
//   meas_valid  one-cycle pulse, meas_count/meas_good just updated
//   meas_count  cycle count of the last completed window
//   meas_good   range-check result of the last completed window
//   stall       one-cycle pulse when a window times out
//   err_sticky  bad window or stall seen after lock, cleared only by reset
interface pll_freq_monitor_if #(
    parameter int CNT_W = 16
);
    logic             ref_toggle;
    logic             locked;
    logic             meas_valid;
    logic [CNT_W-1:0] meas_count;
    logic             meas_good;
    logic             stall;
    logic             err_sticky;

    modport master (
        input  ref_toggle,
        output locked, meas_valid, meas_count, meas_good, stall, err_sticky
    );

    modport slave (
        output ref_toggle,
        input  locked, meas_valid, meas_count, meas_good, stall, err_sticky
    );
endinterface

// File: rtl/pll_freq_monitor.sv
// pll_freq_monitor
//   Runs in the PLL system clock domain (clkin). It measures how many clkin cycles fall
//   between consecutive edges of a slow reference toggle from the crystal domain.
//   Each completed window is range-checked against EXPECTED +/- TOL.
//   `locked` asserts after LOCK_WINDOWS consecutive good windows.
//
//   Ports:
//     clkin   the monitored PLL system clock (the only clock)
//     reset   synchronous, active-high reset
//     mon     pll_freq_monitor_if.master: ref_toggle in; locked, meas_valid,
//             meas_count, meas_good, stall, err_sticky out
//
//   Optional build macro PLL_FREQ_MON_HYST_EN:
//     When it is defined, a locked monitor tolerates one isolated bad window or stall.
//     Lock drops only after two consecutive bad events.
//     When it is undefined, the first bad event drops lock.
module pll_freq_monitor #(
    parameter int CNT_W        = 16,
    parameter int EXPECTED     = 1000,
    parameter int TOL          = 8,
    parameter int LOCK_WINDOWS = 4
) (
    input  logic               clkin,
    input  logic               reset,
    pll_freq_monitor_if.master mon
);
    localparam logic [CNT_W-1:0] LO_VAL      = CNT_W'(EXPECTED - TOL);
    localparam logic [CNT_W-1:0] HI_VAL      = CNT_W'(EXPECTED + TOL);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(EXPECTED + TOL + 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam int               RUN_W       = $clog2(LOCK_WINDOWS + 1);
    localparam logic [RUN_W-1:0] RUN_FULL    = RUN_W'(LOCK_WINDOWS);

    // The timeout must be reachable before the counter saturates.
    if (EXPECTED + TOL + 1 >= (1 << CNT_W)) begin : g_bad_params
        $error("pll_freq_monitor: EXPECTED+TOL+1 must be below 2**CNT_W");
    end

    typedef enum logic {SYNC, MEASURE} state_t;

    state_t           state_q, state_d;
    logic             s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [CNT_W-1:0] counter_q, counter_d;
    logic             meas_valid_q, meas_valid_d;
    logic [CNT_W-1:0] meas_count_q, meas_count_d;
    logic             meas_good_q, meas_good_d;
    logic             stall_q, stall_d;
    logic [RUN_W-1:0] good_run_q, good_run_d;
    logic             locked_q, locked_d;
    logic             err_sticky_q, err_sticky_d;
`ifdef PLL_FREQ_MON_HYST_EN
    logic             bad_run_q, bad_run_d;
`endif

    logic             ref_edge;
    logic             timeout;
    logic             good_evt;
    logic             bad_evt;
    logic [RUN_W-1:0] run_inc;

    assign ref_edge = s2_q ^ s3_q;
    // An edge on the timeout cycle wins, so timeout requires no edge.
    assign timeout  = (state_q == MEASURE) && !ref_edge && (counter_q == TIMEOUT_VAL);
    // Lock bookkeeping works off the registered window result, so `locked` trails meas_valid/stall by one cycle.
    assign good_evt = meas_valid_q && meas_good_q;
    assign bad_evt  = (meas_valid_q && !meas_good_q) || stall_q;
    assign run_inc  = (good_run_q == RUN_FULL) ? good_run_q : good_run_q + RUN_W'(1);

    always_ff @(posedge clkin) begin
        if (reset) begin
            state_q      <= SYNC;
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            s3_q         <= 1'b0;
            counter_q    <= '0;
            meas_valid_q <= 1'b0;
            meas_count_q <= '0;
            meas_good_q  <= 1'b0;
            stall_q      <= 1'b0;
            good_run_q   <= '0;
            locked_q     <= 1'b0;
            err_sticky_q <= 1'b0;
`ifdef PLL_FREQ_MON_HYST_EN
            bad_run_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            s3_q         <= s3_d;
            counter_q    <= counter_d;
            meas_valid_q <= meas_valid_d;
            meas_count_q <= meas_count_d;
            meas_good_q  <= meas_good_d;
            stall_q      <= stall_d;
            good_run_q   <= good_run_d;
            locked_q     <= locked_d;
            err_sticky_q <= err_sticky_d;
`ifdef PLL_FREQ_MON_HYST_EN
            bad_run_q    <= bad_run_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SYNC:    if (ref_edge) state_d = MEASURE;
            MEASURE: if (timeout)  state_d = SYNC;
            default: state_d = SYNC;
        endcase
    end

    // Window measurement: the counter restarts at 1 on every edge, so its value on the next edge is the edge-to-edge distance.
    always_comb begin
        s1_d         = mon.ref_toggle;
        s2_d         = s1_q;
        s3_d         = s2_q;
        counter_d    = counter_q;
        meas_valid_d = 1'b0;
        meas_count_d = meas_count_q;
        meas_good_d  = meas_good_q;
        stall_d      = 1'b0;
        case (state_q)
            SYNC: begin
                if (ref_edge) counter_d = CNT_W'(1);
            end
            MEASURE: begin
                if (ref_edge) begin
                    meas_valid_d = 1'b1;
                    meas_count_d = counter_q;
                    meas_good_d  = (counter_q >= LO_VAL) && (counter_q <= HI_VAL);
                    counter_d    = CNT_W'(1);
                end else if (timeout) begin
                    stall_d   = 1'b1;
                    counter_d = '0;
                end else begin
                    counter_d = (counter_q == CNT_MAX) ? counter_q : counter_q + CNT_W'(1);
                end
            end
            default: counter_d = '0;
        endcase
    end

    // Good-run, lock and sticky-error tracking.
    always_comb begin
        good_run_d   = good_run_q;
        locked_d     = locked_q;
        err_sticky_d = err_sticky_q;
`ifdef PLL_FREQ_MON_HYST_EN
        bad_run_d    = bad_run_q;
`endif
        if (good_evt) begin
            good_run_d = run_inc;
            if (run_inc == RUN_FULL) locked_d = 1'b1;
`ifdef PLL_FREQ_MON_HYST_EN
            bad_run_d = 1'b0;
`endif
        end else if (bad_evt) begin
            good_run_d = '0;
            if (locked_q) err_sticky_d = 1'b1;
`ifdef PLL_FREQ_MON_HYST_EN
            // The first bad event while locked is only remembered. The second consecutive one drops lock.
            if (locked_q && !bad_run_q) begin
                bad_run_d = 1'b1;
            end else begin
                bad_run_d = 1'b0;
                locked_d  = 1'b0;
            end
`else
            locked_d = 1'b0;
`endif
        end
    end

    assign mon.locked     = locked_q;
    assign mon.meas_valid = meas_valid_q;
    assign mon.meas_count = meas_count_q;
    assign mon.meas_good  = meas_good_q;
    assign mon.stall      = stall_q;
    assign mon.err_sticky = err_sticky_q;
endmodule

// File: tb/tb_pll_freq_monitor.sv
// tb_pll_freq_monitor
//   Drives the monitor with directed window sequences and a randomized tail.
//   An event-level reference model predicts every output cycle by cycle.
//   The model works from reference edge times: a toggle made just after posedge T is seen as an edge at posedge T+3.
module tb_pll_freq_monitor;
    localparam int CNT_W        = 16;
    localparam int EXPECTED     = 1000;
    localparam int TOL          = 8;
    localparam int LOCK_WINDOWS = 4;
    localparam int TIMEOUT_LEN  = EXPECTED + TOL + 1;
`ifdef PLL_FREQ_MON_HYST_EN
    localparam logic HYST = 1'b1;
`else
    localparam logic HYST = 1'b0;
`endif

    logic clkin;
    logic reset;
    logic ref_toggle;

    pll_freq_monitor_if #(.CNT_W(CNT_W)) bus ();
    assign bus.ref_toggle = ref_toggle;

    pll_freq_monitor #(
        .CNT_W(CNT_W), .EXPECTED(EXPECTED), .TOL(TOL), .LOCK_WINDOWS(LOCK_WINDOWS)
    ) dut (
        .clkin(clkin),
        .reset(reset),
        .mon(bus)
    );

    initial begin
        clkin = 1'b0;
        forever #5 clkin = ~clkin;
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_tog = 0;
    int stall_cnt = 0;
    bit chk_en = 0;
    int edge_q[$];

    // Reference model state
    bit   m_synced;
    int   m_last_edge;
    int   m_good_run;
    int   m_bad_run;
    logic m_locked, m_valid, m_good, m_stall, m_err;
    int   m_count;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clkin) begin
        bit good_evt, bad_evt, is_edge;
        cyc++;
        if (reset) begin
            m_synced = 0; m_last_edge = 0; m_good_run = 0; m_bad_run = 0;
            m_locked = 0; m_valid = 0; m_good = 0; m_stall = 0; m_err = 0; m_count = 0;
            edge_q.delete();
        end else begin
            // Lock follows the window result reported on the previous cycle.
            good_evt = m_valid && m_good;
            bad_evt  = (m_valid && !m_good) || m_stall;
            if (good_evt) begin
                if (m_good_run < LOCK_WINDOWS) m_good_run++;
                if (m_good_run == LOCK_WINDOWS) m_locked = 1;
                m_bad_run = 0;
            end else if (bad_evt) begin
                if (m_locked) m_err = 1;
                m_good_run = 0;
                if (HYST && m_locked) begin
                    m_bad_run++;
                    if (m_bad_run >= 2) begin
                        m_locked = 0;
                        m_bad_run = 0;
                    end
                end else begin
                    m_locked = 0;
                    m_bad_run = 0;
                end
            end
            m_valid = 0;
            m_stall = 0;
            is_edge = (edge_q.size() > 0) && (edge_q[0] == cyc);
            if (is_edge) void'(edge_q.pop_front());
            if (is_edge) begin
                if (m_synced) begin
                    m_valid = 1;
                    m_count = cyc - m_last_edge;
                    m_good  = (m_count >= EXPECTED - TOL) && (m_count <= EXPECTED + TOL);
                end
                m_synced = 1;
                m_last_edge = cyc;
            end else if (m_synced && (cyc - m_last_edge == TIMEOUT_LEN)) begin
                m_stall = 1;
                m_synced = 0;
            end
        end
    end

    logic [31:0] prev_dut, prev_exp;
    bit first_chk = 1;
    always @(negedge clkin) begin
        logic [31:0] dut_vec, exp_vec;
        if (chk_en) begin
            dut_vec = {11'b0, bus.locked, bus.meas_valid, bus.meas_good, bus.stall, bus.err_sticky, bus.meas_count};
            exp_vec = {11'b0, m_locked, m_valid, m_good, m_stall, m_err, 16'(m_count)};
            if (first_chk || dut_vec !== prev_dut || exp_vec !== prev_exp)
                checkOutput($sformatf("cyc%0d", cyc), dut_vec, exp_vec);
            prev_dut = dut_vec;
            prev_exp = exp_vec;
            first_chk = 0;
            if (bus.stall) stall_cnt++;
        end
    end

    task automatic toggleNow();
        @(posedge clkin);
        #1;
        ref_toggle = ~ref_toggle;
        last_tog = cyc;
        edge_q.push_back(cyc + 3);
    endtask

    task automatic applyStimulus(input int gap);
        while (cyc < last_tog + gap) begin
            @(posedge clkin);
            #1;
        end
        ref_toggle = ~ref_toggle;
        last_tog = cyc;
        edge_q.push_back(cyc + 3);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clkin);
        @(negedge clkin);
    endtask

    task automatic doReset();
        @(posedge clkin);
        #1;
        reset = 1'b1;
        ref_toggle = 1'b0;
        repeat (5) @(posedge clkin);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        ref_toggle = 1'b0;
        @(posedge clkin);
        chk_en = 1;
        repeat (4) @(posedge clkin);
        @(negedge clkin);
        checkOutput("rst_locked", {31'b0, bus.locked}, 32'd0);
        checkOutput("rst_valid",  {31'b0, bus.meas_valid}, 32'd0);
        checkOutput("rst_good",   {31'b0, bus.meas_good}, 32'd0);
        checkOutput("rst_stall",  {31'b0, bus.stall}, 32'd0);
        checkOutput("rst_err",    {31'b0, bus.err_sticky}, 32'd0);
        checkOutput("rst_count",  {16'b0, bus.meas_count}, 32'd0);
        @(posedge clkin);
        #1;
        reset = 1'b0;

        // Nominal lock
        toggleNow();
        repeat (5) applyStimulus(1000);
        waitCycles(6);
        checkOutput("nom_locked", {31'b0, bus.locked}, 32'd1);
        checkOutput("nom_err", {31'b0, bus.err_sticky}, 32'd0);

        // Tolerance bounds, including an edge exactly at the timeout count
        doReset();
        stall_cnt = 0;
        toggleNow();
        applyStimulus(992);
        applyStimulus(1008);
        applyStimulus(991);
        applyStimulus(1009);
        waitCycles(6);
        checkOutput("tol_count", {16'b0, bus.meas_count}, 32'd1009);
        checkOutput("tol_good", {31'b0, bus.meas_good}, 32'd0);
        checkOutput("tol_locked", {31'b0, bus.locked}, 32'd0);
        checkOutput("tol_nostall", stall_cnt, 32'd0);

        // Lock, then lose it with an over-long window
        repeat (4) applyStimulus(1000);
        waitCycles(6);
        checkOutput("relock_locked", {31'b0, bus.locked}, 32'd1);
        applyStimulus(1020);
        waitCycles(3);
        checkOutput("loss_locked", {31'b0, bus.locked}, {31'b0, HYST});
        checkOutput("loss_err", {31'b0, bus.err_sticky}, 32'd1);

        // Relock, then a stuck reference
        repeat (4) applyStimulus(1000);
        waitCycles(6);
        stall_cnt = 0;
        waitCycles(2500);
        checkOutput("stuck_stalls", stall_cnt, 32'd1);
        checkOutput("stuck_locked", {31'b0, bus.locked}, {31'b0, HYST});

        // Reset in the middle of a window, then a clean relock
        toggleNow();
        repeat (2) applyStimulus(1000);
        waitCycles(500);
        @(posedge clkin);
        #1;
        reset = 1'b1;
        ref_toggle = 1'b0;
        @(posedge clkin);
        @(negedge clkin);
        checkOutput("midrst_outs",
            {11'b0, bus.locked, bus.meas_valid, bus.meas_good, bus.stall, bus.err_sticky, bus.meas_count}, 32'd0);
        repeat (4) @(posedge clkin);
        #1;
        reset = 1'b0;
        toggleNow();
        repeat (5) applyStimulus(1000);
        waitCycles(6);
        checkOutput("relock2_locked", {31'b0, bus.locked}, 32'd1);
        checkOutput("relock2_err", {31'b0, bus.err_sticky}, 32'd0);

        // Isolated and consecutive bad windows while locked
        applyStimulus(1000);
        applyStimulus(1030);
        waitCycles(3);
        checkOutput("hyst_mid_locked", {31'b0, bus.locked}, {31'b0, HYST});
        checkOutput("hyst_mid_err", {31'b0, bus.err_sticky}, 32'd1);
        applyStimulus(1000);
        applyStimulus(1030);
        applyStimulus(1030);
        waitCycles(6);
        checkOutput("hyst_end_locked", {31'b0, bus.locked}, 32'd0);
        checkOutput("hyst_end_err", {31'b0, bus.err_sticky}, 32'd1);

        // Randomized windows around the acceptance band
        doReset();
        toggleNow();
        for (int i = 0; i < 20; i++) applyStimulus(int'($urandom_range(1035, 985)));
        waitCycles(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pll_freq_monitor.md
Name: pll_freq_monitor

Overview:
- Checks that the 100 MHz system clock from the on-chip PLL is running at the correct frequency.
- Runs in the PLL output domain and counts system-clock cycles between edges of a slow toggle signal produced in the 24 MHz crystal domain.
- Compares each count against an expected window and asserts `locked` after a run of consecutive good windows.
- Feeds the game's reset and sequencing logic, and drives a status LED.

Parameters:
- CNT_W, 16 — width of the cycle counter and of `meas_count`.
- EXPECTED, 1000 — nominal `clkin` cycles per reference half-period.
- TOL, 8 — allowed deviation; a window is good when EXPECTED-TOL <= count <= EXPECTED+TOL.
- LOCK_WINDOWS, 4 — consecutive good windows required before `locked` asserts.

Ports:
- clkin       input   1      the single clock: the PLL system clock being monitored.
- reset       input   1      synchronous, active-high reset.
- ref_toggle  input   1      asynchronous reference; toggles once per reference half-period.
- locked      output  1      frequency-in-range indication.
- meas_valid  output  1      one-cycle pulse; `meas_count` has just been updated.
- meas_count  output  CNT_W  cycle count of the last completed window.
- meas_good   output  1      result of the last completed window (1 = in range); valid with `meas_valid`.
- stall       output  1      one-cycle pulse when a window times out.
- err_sticky  output  1      set by any bad window or stall after first lock; cleared only by reset.

Behaviour:
- Reset values: every output is 0; counter = 0; good-run = 0; state = SYNC; synchroniser flops = 0.
- Synchroniser and edge detect: `ref_toggle` passes through 2 flops (s1, s2) plus a history flop s3. edge = s2 XOR s3.
- State SYNC: waits for the first edge; no measurement is reported. On edge: counter <= 1, go to MEASURE. The partial window after reset is always discarded.
- State MEASURE, no edge: counter increments by 1.
- State MEASURE, edge: window count = counter value on the edge cycle, i.e. the distance in cycles between consecutive edges.
  - Next cycle: `meas_count` = count, `meas_valid` = 1, `meas_good` = range check.
  - counter <= 1 on the edge cycle, so measurement is back-to-back with no dead cycle.
- Timeout: when counter reaches EXPECTED+TOL+1 with no edge:
  - `stall` pulses on the next cycle.
  - The window is treated as bad; `meas_valid` is not asserted.
  - counter <= 0 and state returns to SYNC.
- Arithmetic: counter saturates at 2^CNT_W-1; it can never wrap, because timeout always fires first. A parameter check requires EXPECTED+TOL+1 < 2^CNT_W.
- Good-run counter:
  - Increments on a good window, saturating at LOCK_WINDOWS.
  - Clears on a bad window or stall.
- `locked`:
  - Asserts on the cycle after `meas_valid` whose good window brings the good-run to LOCK_WINDOWS.
  - Deasserts on the cycle after a bad `meas_valid` or after `stall`.
- `err_sticky`: set when a bad window or stall occurs while `locked` = 1.
- Simultaneous events:
  - An edge on the same cycle the counter hits the timeout value counts as an edge, not a timeout; the window is measured and range-checked.
  - `reset` has priority over everything.
- Reset mid-window: the measurement is abandoned and `locked` drops on the next cycle. No `meas_valid` is issued for the abandoned window.

Optional Feature:
- Macro: PLL_FREQ_MON_HYST_EN.
- Defined: once `locked` = 1, a single bad window does not drop lock.
  - `locked` deasserts only after two consecutive bad windows or stalls.
  - A good window between them resets the bad-run count.
  - `err_sticky` still sets on the first bad event.
- Undefined: `locked` drops on the first bad window or stall, as described in Behaviour.

Test Plan:
- Nominal lock: reset 5 cycles, then toggle `ref_toggle` every 1000 cycles. Required: first edge gives no `meas_valid`; every later window gives `meas_count` = 1000 with `meas_good` = 1; `locked` rises one cycle after the 4th `meas_valid`; `err_sticky` = 0.
- Tolerance bounds: windows of 992, 1008, 991 and 1009 cycles. Required: `meas_good` = 1, 1, 0, 0 respectively; good-run clears on 991; `locked` stays 0 throughout.
- Loss of lock: lock as in the nominal test, then one window of 1020 cycles. Required: timeout `stall` pulse 1009 cycles after the last edge; `locked` = 0 and `err_sticky` = 1 on the next cycle; the next edge only resyncs (no `meas_valid`).
- Stuck reference: lock, then hold `ref_toggle` constant. Required: exactly one `stall` pulse, `locked` falls, and no further `stall` pulses while stuck.
- Edge at timeout boundary: window length exactly 1009. Required: an edge arriving with the counter at 1009 gives `meas_valid` with `meas_count` = 1009 and `meas_good` = 0, and no `stall`. Reset asserted mid-window: all outputs 0 next cycle, followed by a clean relock after 5 good windows.
- With PLL_FREQ_MON_HYST_EN: while locked, windows of 1000, 1030, 1000, 1030, 1030. Required: `locked` stays 1 through the first bad window, drops after the second consecutive bad one; `err_sticky` = 1 from the first bad window.
